// File: rtl/ucaspian_pkg.sv
// ucaspian_pkg: shared activity-mask widths, types and popcount helper
package ucaspian_pkg;
  localparam int ACT_N = 16;
  localparam int ACT_IDX_W = 4;
  typedef logic [ACT_N-1:0] act_mask_t;
  typedef logic [ACT_IDX_W-1:0] act_idx_t;
  typedef logic [4:0] act_cnt_t;
  function automatic act_cnt_t act_popcnt(act_mask_t m);
    act_cnt_t c;
    c = '0;
    for (int i = 0; i < ACT_N; i++) c = c + act_cnt_t'(m[i]);
    return c;
  endfunction
endpackage

// File: rtl/bit_index_decode_16.sv
// bit_index_decode_16: 4-to-16 one-hot decoder with enable
module bit_index_decode_16
  import ucaspian_pkg::*;
(
  input  logic      en,
  input  act_idx_t  idx,
  output act_mask_t oh
);
  assign oh = en ? act_mask_t'(1) << idx : '0;
endmodule

// File: rtl/find_set_bit_16.sv
// find_set_bit_16: lowest-set-bit priority encoder over 16 bits
module find_set_bit_16
  import ucaspian_pkg::*;
(
  input  act_mask_t vec,
  output act_idx_t  idx,
  output logic      none_found
);
  always_comb begin
    idx = '0;
    for (int i = ACT_N - 1; i >= 0; i--) if (vec[i]) idx = act_idx_t'(i);
  end
  assign none_found = ~|vec;
endmodule

// File: rtl/activity_mask_16.sv
// activity_mask_16: pending activity bitmap, lowest-first drain; optional dup counter via ACTIVITY_MASK_DUP_CNT_EN
module activity_mask_16
  import ucaspian_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     set_valid,
  input  act_idx_t set_idx,
  input  logic     clear_all,
  output logic     out_valid,
  output act_idx_t out_idx,
  input  logic     out_ready,
  output logic     empty,
  output act_cnt_t pending_cnt,
  output logic     dup_set
`ifdef ACTIVITY_MASK_DUP_CNT_EN
  ,
  input  logic       dup_cnt_clr,
  output logic [7:0] dup_cnt
`endif
);
  act_mask_t mask, mask_n, set_oh, clr_oh;
  logic drain, dup;
  bit_index_decode_16 u_set_dec (.en(set_valid), .idx(set_idx), .oh(set_oh));
  bit_index_decode_16 u_clr_dec (.en(drain), .idx(out_idx), .oh(clr_oh));
  find_set_bit_16 u_find (.vec(mask), .idx(out_idx), .none_found(empty));
  assign out_valid = ~empty;
  assign drain = out_valid & out_ready;
  assign mask_n = clear_all ? set_oh : (mask & ~clr_oh) | set_oh;
  assign dup = set_valid & mask[set_idx] & ~clr_oh[set_idx] & ~clear_all;
  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
      pending_cnt <= '0;
      dup_set <= 1'b0;
    end else begin
      mask <= mask_n;
      pending_cnt <= act_popcnt(mask_n);
      dup_set <= dup;
    end
  end
`ifdef ACTIVITY_MASK_DUP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) dup_cnt <= '0;
    else if (dup_cnt_clr) dup_cnt <= {7'd0, dup_set};
    else if (dup_set && dup_cnt != 8'hff) dup_cnt <= dup_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_activity_mask_16.sv
// tb_activity_mask_16: directed self-checking bench for activity_mask_16
module tb_activity_mask_16;
  logic clk = 0, reset = 1, set_valid = 0, clear_all = 0, out_ready = 0;
  logic [3:0] set_idx = '0, out_idx;
  logic out_valid, empty, dup_set;
  logic [4:0] pending_cnt;
  int checks = 0, errors = 0;
`ifdef ACTIVITY_MASK_DUP_CNT_EN
  logic dup_cnt_clr = 0;
  logic [7:0] dup_cnt;
`endif
  activity_mask_16 dut (
    .clk(clk), .reset(reset), .set_valid(set_valid), .set_idx(set_idx),
    .clear_all(clear_all), .out_valid(out_valid), .out_idx(out_idx),
    .out_ready(out_ready), .empty(empty), .pending_cnt(pending_cnt), .dup_set(dup_set)
`ifdef ACTIVITY_MASK_DUP_CNT_EN
    , .dup_cnt_clr(dup_cnt_clr), .dup_cnt(dup_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic v, logic [3:0] idx, logic [4:0] cnt, logic d);
    logic [11:0] obs, exp;
    obs = {out_valid, empty, out_idx, pending_cnt, dup_set};
    exp = {v, ~v, idx, cnt, d};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs(v,e,idx,cnt,dup)=%b_%b_%0d_%0d_%b exp=%b_%b_%0d_%0d_%b", tag,
             obs[11], obs[10], obs[9:6], obs[5:1], obs[0], exp[11], exp[10], exp[9:6], exp[5:1], exp[0]);
    end
  endtask
  task automatic post(logic [3:0] i);
    set_valid = 1; set_idx = i;
    tick();
    set_valid = 0;
  endtask
  initial begin
    tick(); tick();
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle", 0, 0, 0, 0);
    end
    post(9);  chk("set9", 1, 9, 1, 0);
    post(3);  chk("set3", 1, 3, 2, 0);
    post(12); chk("set12", 1, 3, 3, 0);
    out_ready = 1;
    tick(); chk("drain3", 1, 9, 2, 0);
    tick(); chk("drain9", 1, 12, 1, 0);
    tick(); chk("drain12", 0, 0, 0, 0);
    tick(); chk("ready_empty", 0, 0, 0, 0);
    out_ready = 0;
    post(5); chk("set5", 1, 5, 1, 0);
    out_ready = 1;
    post(5); chk("set_drain_same", 1, 5, 1, 0);
    tick(); chk("drain5", 0, 0, 0, 0);
    out_ready = 0;
    post(7); chk("set7", 1, 7, 1, 0);
    post(7); chk("dup7", 1, 7, 1, 1);
    tick(); chk("dup7_end", 1, 7, 1, 0);
    post(10); chk("preempt_pre", 1, 7, 2, 0);
    post(2);  chk("preempt", 1, 2, 3, 0);
    clear_all = 1;
    tick(); chk("clear_a", 0, 0, 0, 0);
    clear_all = 0;
    post(1); post(4); post(15);
    chk("set_1_4_15", 1, 1, 3, 0);
    clear_all = 1;
    post(8); chk("clear_set8", 1, 8, 1, 0);
    tick(); chk("clear_alone", 0, 0, 0, 0);
    clear_all = 0;
    for (int i = 15; i >= 0; i--) post(4'(i));
    chk("all16", 1, 0, 16, 0);
    out_ready = 1; set_valid = 1; set_idx = 3; reset = 1;
    tick(); chk("reset_mid", 0, 0, 0, 0);
    reset = 0; set_valid = 0; out_ready = 0;
    tick(); chk("post_reset", 0, 0, 0, 0);
`ifdef ACTIVITY_MASK_DUP_CNT_EN
    checks++;
    assert (dup_cnt === 8'd0) else begin errors++; $error("FAIL dupcnt_rst obs=%0d exp=0", dup_cnt); end
    post(6);
    set_valid = 1; set_idx = 6;
    for (int i = 0; i < 300; i++) tick();
    checks++;
    assert (dup_cnt === 8'd255) else begin errors++; $error("FAIL dupcnt_sat obs=%0d exp=255", dup_cnt); end
    dup_cnt_clr = 1;
    tick();
    dup_cnt_clr = 0; set_valid = 0;
    checks++;
    assert (dup_cnt === 8'd1) else begin errors++; $error("FAIL dupcnt_clr obs=%0d exp=1", dup_cnt); end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/activity_mask_16.md
Name: activity_mask_16

Overview:
- 16-entry activity bitmap and the write side of activity-driven scheduling.
- Producers post 4-bit element indices (neuron or synapse slots). Each index is decoded to one-hot and OR'd into a pending mask.
- A consumer drains the pending indices lowest-index-first through a valid/ready port. The lowest set bit is selected by the existing find_set_bit_16 priority encoder, and each drained bit is cleared.
- Sits between the spike/accumulate stage (sets bits) and the per-timestep fire/leak scan (drains bits).

Parameters:
- N, 16, mask width; fixed at 16, other values unsupported.
- IDX_W, 4, index width; fixed at 4.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- set_valid  in  1  post an index this cycle; always accepted, no ready
- set_idx  in  4  index to mark pending
- clear_all  in  1  discard all pending bits (timestep boundary)
- out_valid  out  1  at least one bit pending
- out_idx  out  4  lowest pending index
- out_ready  in  1  consumer accepts out_idx this cycle
- empty  out  1  no bits pending
- pending_cnt  out  5  number of pending bits, 0..16
- dup_set  out  1  one-cycle pulse: previous cycle's set hit an already-pending bit

Behaviour:
- State: mask[15:0]; pending_cnt and dup_set registers.
- Reset (synchronous, reset=1 at clk edge):
  - mask=0, pending_cnt=0, dup_set=0.
  - Hence out_valid=0, out_idx=0, empty=1.
  - Reset mid-operation discards all pending bits; inputs in that cycle are ignored.
- Derived outputs, combinational from registered mask only:
  - out_valid = |mask; empty = ~out_valid.
  - out_idx = index of lowest set bit; 0 when mask=0.
- Per-cycle signals:
  - set_oh = set_valid ? (1<<set_idx) : 0
  - drain = out_valid & out_ready; clr_oh = drain ? (1<<out_idx) : 0
- Next state, priority clear_all < set, drain < set:
  - clear_all=1: mask_n = set_oh.
  - else: mask_n = (mask & ~clr_oh) | set_oh.
- Set and drain of the same index in one cycle: bit stays set. This counts as fresh activity and is reported again later.
- out_ready while out_valid=0: no effect.
- Latency:
  - A set is visible on out_valid/out_idx the cycle after set_valid.
  - A drained bit is gone the cycle after the handshake.
  - Back-to-back draining gives one index per cycle.
- pending_cnt: registered popcount(mask_n), so it always equals popcount(mask); max 16, no wrap possible.
- dup_set: registers set_valid & mask[set_idx] & ~(clr_oh[set_idx]) & ~clear_all.
  - Pulses exactly one cycle.
  - Mask unchanged by the duplicate.
- out_idx stability: holds while out_valid=1 and out_ready=0, unless a set arrives at a lower index. A lower index may preempt; the consumer must sample out_idx only on the handshake.

Optional Feature:
- Macro: ACTIVITY_MASK_DUP_CNT_EN.
- Defined:
  - Adds output dup_cnt [7:0]: saturating count of dup_set events, held at 255.
  - Adds input dup_cnt_clr [1]: zeroes it next cycle; if a dup event occurs in the same cycle, the result is 1.
  - Reset value 0.
- Undefined: ports absent, no counter logic; all other behaviour identical.

Decomposition:
- Shared package (ucaspian_pkg):
  - localparams ACT_N=16, ACT_IDX_W=4
  - typedefs act_mask_t (logic[15:0]), act_idx_t (logic[3:0]), act_cnt_t (logic[4:0])
- Sub-module bit_index_decode_16 (new): combinational 4→16 one-hot decoder with enable. Used twice, for set_oh and clr_oh.
- Lowest-bit selection instantiates the existing find_set_bit_16; its none_found output drives empty.

Test Plan:
- Reset then idle 5 cycles → out_valid=0, empty=1, out_idx=0, pending_cnt=0, dup_set=0 every cycle.
- Set idx 9, 3, 12 on consecutive cycles, out_ready=1 from the cycle after the last set:
  - Drain order 3, 9, 12 on three consecutive cycles.
  - pending_cnt 3→2→1→0; empty=1 after the last drain.
- mask={5}, out_ready=1, and set_valid with set_idx=5 in the same cycle → next cycle out_valid=1, out_idx=5, pending_cnt=1, dup_set=0.
- mask={7}, out_ready=0, set idx 7 → dup_set=1 for exactly one cycle; pending_cnt stays 1.
- mask={1,4,15}, clear_all=1 with set idx 8 → next cycle mask={8}, out_idx=8, pending_cnt=1. Then clear_all alone → empty=1.
- Set all 16 indices over 16 cycles → pending_cnt=16, out_idx=0. Assert reset with out_ready=1 → next cycle all outputs at reset values. With ACTIVITY_MASK_DUP_CNT_EN defined, 300 duplicate sets → dup_cnt=255.
